// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer.
//   sb_entry_t : one buffered store {addr, data, is_half, is_byte}
//   sb_state_t : sync sequencing state {RUN, SYNC_DRAIN}
//   SB_WORD_LSB: lowest address bit used by the word-granular hit compare
// Entry field widths are fixed here, so the top-level ADDR_W/DATA_W must
// keep their default values (SB_ADDR_W/SB_DATA_W).
package store_buffer_pkg;

    localparam int unsigned SB_ADDR_W   = 32;
    localparam int unsigned SB_DATA_W   = 32;
    localparam int unsigned SB_WORD_LSB = 2;

    typedef enum logic {
        RUN        = 1'b0,
        SYNC_DRAIN = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic                 is_half;
        logic                 is_byte;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_sb_fifo.sv
// sb_fifo: circular store queue with head/tail pointers and occupancy count.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset (clears pointers/count)
//   push_i/push_entry_i: append an entry at the tail
//   pop_i             : retire the head entry
//   match_addr_i      : word address compared against every valid entry
//   match_o           : per-entry hit vector, age ordered (bit 0 = oldest)
//   head_o            : oldest entry
//   count_o           : occupancy
//   fwd_age_i/fwd_entry_o : age-indexed read port (only with SB_FORWARD_EN)
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                push_i,
    input  sb_entry_t                           push_entry_i,
    input  logic                                pop_i,
    input  logic [SB_ADDR_W-1:SB_WORD_LSB]      match_addr_i,
    output logic [DEPTH-1:0]                    match_o,
    output sb_entry_t                           head_o,
`ifdef SB_FORWARD_EN
    input  logic [$clog2(DEPTH)-1:0]            fwd_age_i,
    output sb_entry_t                           fwd_entry_o,
`endif
    output logic [$clog2(DEPTH):0]              count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   idx;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        head_d  = pop_i  ? head_q + 1'b1 : head_q;
        tail_d  = push_i ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i) begin
                mem_q[tail_q] <= push_entry_i;
            end
        end
    end

    // Age-ordered view so the top can pick the youngest match by priority.
    always_comb begin
        match_o = '0;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx        = head_q + PW'(k);
            match_o[k] = (CW'(k) < count_q) &&
                         (mem_q[idx].addr[SB_ADDR_W-1:SB_WORD_LSB] == match_addr_i);
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

`ifdef SB_FORWARD_EN
    assign fwd_entry_o = mem_q[head_q + fwd_age_i];
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: per-core posted-write buffer between EX/MEM and the data port.
// Stores are queued and drained in order whenever the port is granted and not
// used by a load; loads hitting a buffered word stall (or forward, see below).
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   EX_MEM_*            : pipeline access (address, data, write/read, size, sync)
//   Mem_Grant           : arbiter grants the memory port this cycle
//   MEM_ReadData        : combinational memory read data
//   SB_Address/WriteData/MemWrite/MemRead/HalfControl/ByteControl : memory port
//   SB_ReadData         : load result (0 when no load completes)
//   SB_Stall            : hold the pipeline
//   SB_Count, SB_Empty  : occupancy
// Optional: define SB_FORWARD_EN to serve word loads whose youngest matching
// entry is a word store directly from the buffer.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [ADDR_W-1:0]       EX_MEM_Address,
    input  logic [DATA_W-1:0]       EX_MEM_WriteData,
    input  logic                    EX_MEM_MemWrite,
    input  logic                    EX_MEM_MemRead,
    input  logic                    EX_MEM_HalfControl,
    input  logic                    EX_MEM_ByteControl,
    input  logic                    EX_MEM_Sync,
    input  logic                    Mem_Grant,
    input  logic [DATA_W-1:0]       MEM_ReadData,
    output logic [ADDR_W-1:0]       SB_Address,
    output logic [DATA_W-1:0]       SB_WriteData,
    output logic                    SB_MemWrite,
    output logic                    SB_MemRead,
    output logic                    SB_HalfControl,
    output logic                    SB_ByteControl,
    output logic [DATA_W-1:0]       SB_ReadData,
    output logic                    SB_Stall,
    output logic [$clog2(DEPTH):0]  SB_Count,
    output logic                    SB_Empty
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    sb_state_t        state_q, state_d;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] match;
    sb_entry_t        head, push_entry;
    logic has_entries, full, hit, is_store, is_load;
    logic sync_stall, load_pass, fwd, drain, push;

    assign push_entry = '{addr: EX_MEM_Address, data: EX_MEM_WriteData,
                          is_half: EX_MEM_HalfControl, is_byte: EX_MEM_ByteControl};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (drain),
        .match_addr_i (EX_MEM_Address[ADDR_W-1:SB_WORD_LSB]),
        .match_o      (match),
        .head_o       (head),
`ifdef SB_FORWARD_EN
        .fwd_age_i    (fwd_age),
        .fwd_entry_o  (fwd_entry),
`endif
        .count_o      (count)
    );

    assign has_entries = (count != '0);
    assign full        = (count == CW'(DEPTH));
    assign hit         = |match;
    assign is_store    = EX_MEM_MemWrite;
    assign is_load     = EX_MEM_MemRead & ~EX_MEM_MemWrite;

    // A sync with data still buffered blocks new accesses from its first cycle.
    assign sync_stall = ((state_q == SYNC_DRAIN) || EX_MEM_Sync) && has_entries;

`ifdef SB_FORWARD_EN
    logic [$clog2(DEPTH)-1:0] fwd_age;
    sb_entry_t                fwd_entry;

    // Last match in age order is the youngest store to that word.
    always_comb begin
        fwd_age = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (match[k]) begin
                fwd_age = ($clog2(DEPTH))'(k);
            end
        end
    end

    assign fwd = !Reset && is_load && !sync_stall && hit &&
                 !EX_MEM_HalfControl && !EX_MEM_ByteControl &&
                 !fwd_entry.is_half && !fwd_entry.is_byte;
`else
    assign fwd = 1'b0;
`endif

    assign load_pass = !Reset && is_load && !sync_stall && !hit && Mem_Grant;
    assign drain     = !Reset && has_entries && Mem_Grant && !load_pass;
    assign push      = !Reset && is_store && !sync_stall && (!full || drain);

    assign SB_Stall = sync_stall || (is_store && !push) || (is_load && !load_pass && !fwd);

    assign SB_MemWrite    = drain;
    assign SB_MemRead     = load_pass;
    assign SB_Address     = load_pass ? EX_MEM_Address     : head.addr;
    assign SB_WriteData   = head.data;
    assign SB_HalfControl = load_pass ? EX_MEM_HalfControl : head.is_half;
    assign SB_ByteControl = load_pass ? EX_MEM_ByteControl : head.is_byte;
    assign SB_Count       = count;
    assign SB_Empty       = !has_entries;

    always_comb begin
        SB_ReadData = '0;
        if (load_pass) begin
            SB_ReadData = MEM_ReadData;
        end
`ifdef SB_FORWARD_EN
        else if (fwd) begin
            SB_ReadData = fwd_entry.data;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:        if (EX_MEM_Sync && has_entries) state_d = SYNC_DRAIN;
            SYNC_DRAIN: if (!has_entries)               state_d = RUN;
            default:                                    state_d = RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, checked against a queue-based reference model and a write/read
// scoreboard. Define SB_FORWARD_EN for both DUT and bench to cover forwarding.
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] EX_MEM_Address, EX_MEM_WriteData;
    logic        EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_HalfControl, EX_MEM_ByteControl;
    logic        EX_MEM_Sync, Mem_Grant;
    logic [31:0] MEM_ReadData;
    logic [31:0] SB_Address, SB_WriteData, SB_ReadData;
    logic        SB_MemWrite, SB_MemRead, SB_HalfControl, SB_ByteControl, SB_Stall, SB_Empty;
    logic [2:0]  SB_Count;

    always #5 Clk = ~Clk;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .EX_MEM_Address(EX_MEM_Address), .EX_MEM_WriteData(EX_MEM_WriteData),
        .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_HalfControl(EX_MEM_HalfControl), .EX_MEM_ByteControl(EX_MEM_ByteControl),
        .EX_MEM_Sync(EX_MEM_Sync), .Mem_Grant(Mem_Grant), .MEM_ReadData(MEM_ReadData),
        .SB_Address(SB_Address), .SB_WriteData(SB_WriteData),
        .SB_MemWrite(SB_MemWrite), .SB_MemRead(SB_MemRead),
        .SB_HalfControl(SB_HalfControl), .SB_ByteControl(SB_ByteControl),
        .SB_ReadData(SB_ReadData), .SB_Stall(SB_Stall),
        .SB_Count(SB_Count), .SB_Empty(SB_Empty)
    );

    // Memory returns a hash of the requested address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction
    assign MEM_ReadData = mem_fn(SB_Address);

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        h;
        logic        b;
    } st_t;

    st_t         mq[$];       // model contents of the buffer, oldest first
    st_t         exp_wr[$];   // memory writes still expected, in order
    logic [31:0] exp_rd[$];   // load addresses awaiting completion
    bit          m_sync = 1'b0;
    bit          last_stall = 1'b0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        EX_MEM_MemWrite = 0; EX_MEM_MemRead = 0; EX_MEM_Sync = 0;
        EX_MEM_HalfControl = 0; EX_MEM_ByteControl = 0;
        EX_MEM_Address = '0; EX_MEM_WriteData = '0;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic h, input logic b);
        set_idle();
        EX_MEM_MemWrite = 1; EX_MEM_Address = a; EX_MEM_WriteData = d;
        EX_MEM_HalfControl = h; EX_MEM_ByteControl = b;
    endtask

    task automatic set_load(input logic [31:0] a, input logic h, input logic b);
        set_idle();
        EX_MEM_MemRead = 1; EX_MEM_Address = a;
        EX_MEM_HalfControl = h; EX_MEM_ByteControl = b;
        exp_rd.push_back(a);
    endtask

    // One clock: check outputs against the model at negedge, advance it at posedge.
    task automatic step();
        int n;
        bit in_sync, st, ld, hit, fwd, ldp, drn, psh, stall;
        st_t yng, e;
        @(negedge Clk);
        n = mq.size();
        if (Reset) begin
            chk("reset_memwrite", SB_MemWrite, 0);
            chk("reset_memread", SB_MemRead, 0);
            @(posedge Clk);
            mq.delete(); exp_wr.delete(); exp_rd.delete();
            m_sync = 0; last_stall = 0;
            #1;
            return;
        end
        in_sync = (m_sync || EX_MEM_Sync) && n > 0;
        st  = EX_MEM_MemWrite;
        ld  = EX_MEM_MemRead && !EX_MEM_MemWrite;
        hit = 0;
        foreach (mq[i]) begin
            if (mq[i].a[31:2] == EX_MEM_Address[31:2]) begin
                hit = 1;
                yng = mq[i];
            end
        end
        fwd   = FWD && ld && !in_sync && hit && !EX_MEM_HalfControl && !EX_MEM_ByteControl
                && !yng.h && !yng.b;
        ldp   = ld && !in_sync && !hit && Mem_Grant;
        drn   = n > 0 && Mem_Grant && !ldp;
        psh   = st && !in_sync && (n < DEPTH || drn);
        stall = in_sync || (st && !psh) || (ld && !ldp && !fwd);
        chk("stall", SB_Stall, stall);
        chk("memwrite", SB_MemWrite, drn);
        chk("memread", SB_MemRead, ldp);
        chk("count", SB_Count, 64'(n));
        chk("empty", SB_Empty, n == 0);
        if (fwd) begin
            chk("fwd_data", SB_ReadData, yng.d);
            if (exp_rd.size() > 0) void'(exp_rd.pop_front());
        end else if (!ldp) begin
            chk("readdata_idle", SB_ReadData, 0);
        end
        e = '{a: EX_MEM_Address, d: EX_MEM_WriteData, h: EX_MEM_HalfControl, b: EX_MEM_ByteControl};
        @(posedge Clk);
        if (drn) void'(mq.pop_front());
        if (psh) begin
            mq.push_back(e);
            exp_wr.push_back(e);
        end
        m_sync = (m_sync || EX_MEM_Sync) && n > 0;
        last_stall = stall;
        #1;
    endtask

    task automatic run_until_free(input int budget);
        int c = 0;
        do begin
            step();
            c++;
        end while (last_stall && c < budget);
        chk("stall_timeout", last_stall, 0);
    endtask

    // Scoreboard monitor: every memory access the DUT presents must match the
    // next expected one.
    st_t         me;
    logic [31:0] ma;
    always @(negedge Clk) begin
        if (!Reset) begin
            if (SB_MemWrite) begin
                if (exp_wr.size() == 0) begin
                    chk("write_unexpected", 1, 0);
                end else begin
                    me = exp_wr.pop_front();
                    chk("wr_addr", SB_Address, me.a);
                    chk("wr_data", SB_WriteData, me.d);
                    chk("wr_half", SB_HalfControl, me.h);
                    chk("wr_byte", SB_ByteControl, me.b);
                end
            end
            if (SB_MemRead) begin
                if (exp_rd.size() == 0) begin
                    chk("read_unexpected", 1, 0);
                end else begin
                    ma = exp_rd.pop_front();
                    chk("rd_addr", SB_Address, ma);
                    chk("rd_data", SB_ReadData, mem_fn(ma));
                end
            end
        end
    end

    int          stalls;
    int unsigned r, sz;
    logic [31:0] addr;

    initial begin
        set_idle();
        Mem_Grant = 0;
        Reset = 1;
        step(); step();
        Reset = 0;
        chk("reset_count", SB_Count, 0);
        chk("reset_empty", SB_Empty, 1);

        // Single store buffered, then drained on grant.
        set_store(32'h100, 32'h1122_3344, 0, 0);
        step();
        set_idle();
        chk("t1_count", SB_Count, 1);
        Mem_Grant = 1;
        step();
        chk("t1_drained", SB_Count, 0);

        // Fill to DEPTH, fifth store stalls then pushes during a drain.
        Mem_Grant = 0;
        for (int i = 0; i < 4; i++) begin
            set_store(32'h10 + 32'(i * 4), $urandom, 0, 0);
            step();
        end
        chk("t2_full", SB_Count, 4);
        set_store(32'h20, 32'hCAFE_0005, 0, 0);
        step();
        chk("t2_full_stall", last_stall, 1);
        Mem_Grant = 1;
        step();
        chk("t2_push_pop", SB_Count, 4);
        set_idle();
        repeat (5) step();
        chk("t2_empty", SB_Empty, 1);

        // Byte store then overlapping word load: stall until drained.
        Mem_Grant = 0;
        set_store(32'h203, 32'h0000_00AB, 0, 1);
        step();
        set_load(32'h200, 0, 0);
        step();
        chk("t3_hit_stall", last_stall, 1);
        Mem_Grant = 1;
        run_until_free(10);
        set_idle();

        // Non-matching load bypasses and defers the pending drain.
        Mem_Grant = 0;
        set_store(32'h500, 32'h5555_AAAA, 1, 0);
        step();
        Mem_Grant = 1;
        set_load(32'h300, 0, 0);
        step();
        chk("t4_no_stall", last_stall, 0);
        chk("t4_deferred", SB_Count, 1);
        set_idle();
        step();
        chk("t4_drained", SB_Count, 0);

        // Sync with three stores buffered.
        Mem_Grant = 0;
        for (int i = 0; i < 3; i++) begin
            set_store(32'h600 + 32'(i * 4), $urandom, 0, 0);
            step();
        end
        set_idle();
        EX_MEM_Sync = 1;
        Mem_Grant = 1;
        stalls = 0;
        do begin
            step();
            if (last_stall) stalls++;
        end while (last_stall && stalls < 10);
        chk("t5_sync_stalls", stalls, 3);
        chk("t5_sync_empty", SB_Empty, 1);
        set_idle();

        // Reset in the middle of a sync drain discards the rest.
        Mem_Grant = 0;
        for (int i = 0; i < 3; i++) begin
            set_store(32'h700 + 32'(i * 4), $urandom, 0, 0);
            step();
        end
        set_idle();
        EX_MEM_Sync = 1;
        Mem_Grant = 1;
        step();
        Reset = 1;
        step();
        Reset = 0;
        set_idle();
        chk("t5_reset_count", SB_Count, 0);
        repeat (3) step();

        // Word store then word load (forwarded when enabled), then half load.
        Mem_Grant = 0;
        set_store(32'h40, 32'hDEAD_BEEF, 0, 0);
        step();
        set_load(32'h40, 0, 0);
        step();
        chk("t6_word_load_stall", last_stall, !FWD);
        Mem_Grant = 1;
        if (last_stall) run_until_free(10);
        set_idle();
        step();
        Mem_Grant = 0;
        set_store(32'h40, 32'hDEAD_BEEF, 0, 0);
        step();
        set_load(32'h42, 1, 0);
        step();
        chk("t6_half_load_stall", last_stall, 1);
        Mem_Grant = 1;
        run_until_free(10);
        set_idle();

        // Random traffic, holding inputs while stalled.
        for (int c = 0; c < 800; c++) begin
            Mem_Grant = ($urandom % 10) < 6;
            if (!last_stall) begin
                r    = $urandom % 10;
                sz   = $urandom % 3;
                addr = 32'h1000 + 32'(($urandom % 6) * 4);
                if (sz == 1) addr = addr + 32'(($urandom % 2) * 2);
                if (sz == 2) addr = addr + 32'($urandom % 4);
                if (r < 4) begin
                    set_store(addr, $urandom, sz == 1, sz == 2);
                    EX_MEM_MemRead = ($urandom % 4) == 0;
                end else if (r < 6) begin
                    set_load(addr, sz == 1, sz == 2);
                end else if (r == 6) begin
                    set_idle();
                    EX_MEM_Sync = 1;
                end else begin
                    set_idle();
                end
            end
            step();
        end
        Mem_Grant = 1;
        if (last_stall) run_until_free(50);
        set_idle();
        repeat (DEPTH + 1) step();
        chk("final_writes_pending", 64'(exp_wr.size()), 0);
        chk("final_reads_pending", 64'(exp_rd.size()), 0);
        chk("final_count", SB_Count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
